// File: rtl/reg_wr_arb.sv
// Round-robin arbiter for a shared register write port with one-cycle grant latency.
// Optional owner lock compiled in by defining REG_WR_ARB_LOCK_EN.
module reg_wr_arb #(
  parameter int unsigned           REQ_NUM    = 4,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0,
  parameter int unsigned           LOCK_MAX   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [REQ_NUM-1:0]            i_req,
`ifdef REG_WR_ARB_LOCK_EN
  input  logic [REQ_NUM-1:0]            i_lock,
`endif
  input  logic [REQ_NUM*DATA_WIDTH-1:0] i_data,
  output logic [REQ_NUM-1:0]            o_gnt,
  output logic [$clog2(REQ_NUM)-1:0]    o_owner,
  output logic                          o_upd,
  output logic [DATA_WIDTH-1:0]         o_data
);

  localparam int unsigned PW = $clog2(REQ_NUM);
  typedef logic [PW-1:0] idx_t;

`ifdef REG_WR_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  state_t                 state_q, state_d;
  idx_t                   ptr_q, ptr_d;
  idx_t                   owner_q, owner_d;
  logic [REQ_NUM-1:0]     gnt_q, gnt_d;
  logic                   upd_q, upd_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
`ifdef REG_WR_ARB_LOCK_EN
  logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

  logic [REQ_NUM-1:0]     arb_req;
  idx_t                   arb_ptr;
  logic                   arb_en;
  idx_t                   win;

  function automatic idx_t inc_idx(input idx_t i);
    if (32'(i) == REQ_NUM - 1) return '0;
    else return i + 1'b1;
  endfunction

  // First asserted request at or above start, wrapping at REQ_NUM-1.
  function automatic idx_t pick(input logic [REQ_NUM-1:0] req, input idx_t start);
    idx_t idx;
    idx_t res;
    logic found;
    idx   = start;
    res   = start;
    found = 1'b0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = inc_idx(idx);
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    gnt_d   = '0;
    upd_d   = 1'b0;
    arb_req = i_req;
    arb_ptr = ptr_q;
    arb_en  = 1'b1;
    win     = '0;
`ifdef REG_WR_ARB_LOCK_EN
    cnt_d   = cnt_q;
    if (state_q == LOCK) begin
      if (i_req[owner_q] && i_lock[owner_q] && cnt_q < CNT_W'(LOCK_MAX)) begin
        arb_en          = 1'b0;
        gnt_d[owner_q]  = 1'b1;
        upd_d           = 1'b1;
        data_d          = i_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
        cnt_d           = cnt_q + 1'b1;
      end else begin
        // Released owner sits out this cycle; others arbitrate from owner+1.
        arb_req[owner_q] = 1'b0;
        arb_ptr          = inc_idx(owner_q);
        ptr_d            = arb_ptr;
        cnt_d            = '0;
      end
    end
`endif
    if (arb_en) begin
      if (|arb_req) begin
        win        = pick(arb_req, arb_ptr);
        gnt_d[win] = 1'b1;
        upd_d      = 1'b1;
        owner_d    = win;
        data_d     = i_data[win*DATA_WIDTH +: DATA_WIDTH];
        ptr_d      = inc_idx(win);
        state_d    = GRANT;
`ifdef REG_WR_ARB_LOCK_EN
        if (i_lock[win]) begin
          state_d = LOCK;
          cnt_d   = CNT_W'(1);
        end
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      upd_q   <= 1'b0;
      data_q  <= RST_VALUE;
`ifdef REG_WR_ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      upd_q   <= upd_d;
      data_q  <= data_d;
`ifdef REG_WR_ARB_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign o_gnt   = gnt_q;
  assign o_owner = owner_q;
  assign o_upd   = upd_q;
  assign o_data  = data_q;

endmodule

// File: doc/reg_wr_arb.md
REG_WR_ARB -- requirements
Module: reg_wr_arb

Interface
REQ-001 Parameter REQ_NUM, default 4: number of requesters sharing the register write port (2..16).
REQ-002 Parameter DATA_WIDTH, default 32: width of the shared register and of each requester's data.
REQ-003 Parameter RST_VALUE, default 0: o_data value under reset.
REQ-004 Parameter LOCK_MAX, default 16: maximum consecutive cycles one owner may hold a lock (2..256).
REQ-005 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  asynchronous, active-high reset.
REQ-007 i_req  input  REQ_NUM  per-requester write request, bit k = requester k.
REQ-008 i_lock  input  REQ_NUM  per-requester lock request; present only when REG_WR_ARB_LOCK_EN is defined.
REQ-009 i_data  input  REQ_NUM*DATA_WIDTH  requester k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 o_gnt  output  REQ_NUM  registered one-hot grant; all-zero when no grant.
REQ-011 o_owner  output  $clog2(REQ_NUM)  binary index of the current or most recent winner.
REQ-012 o_upd  output  1  high for each cycle in which o_data was written this edge.
REQ-013 o_data  output  DATA_WIDTH  shared register contents.

Function
REQ-014 Arbitration is round-robin: the winner is the first asserted i_req bit at or above pointer ptr, wrapping from REQ_NUM-1 to 0.
REQ-015 Latency is one cycle: requests sampled at edge t yield o_gnt, o_owner, o_upd=1 and o_data = winner's i_data, all valid after edge t.
REQ-016 After each arbitration win, ptr <= winner+1 mod REQ_NUM; ptr is unchanged when no request wins.
REQ-017 With all requests held high, grants rotate 0,1,2,...,REQ_NUM-1,0 on consecutive cycles; no requester waits more than REQ_NUM-1 grants.
REQ-018 Handshake: a requester holds i_req until it observes its o_gnt bit; i_req still high in the cycle its grant is visible counts as a new request.
REQ-019 FSM states: IDLE (o_gnt=0), GRANT (single-cycle grant), LOCK (owner retains grant).
REQ-020 IDLE/GRANT -> GRANT when any i_req is high and the winner does not lock; -> IDLE when no i_req is high.
REQ-021 When i_req is all-zero: o_gnt=0, o_upd=0, o_data and o_owner hold.
REQ-022 o_upd is asserted exactly when o_gnt is non-zero.
REQ-023 Data of non-granted requesters never reaches o_data.

Reset
REQ-024 While i_rst is high, independent of i_clk: o_data=RST_VALUE, o_gnt=0, o_upd=0, o_owner=0, ptr=0, lock counter=0, state IDLE.
REQ-025 Reset asserted mid-grant or mid-lock drops o_gnt and o_upd immediately; first grant after release follows ptr=0.

Configuration
REQ-026 Macro REG_WR_ARB_LOCK_EN compiles in the lock feature.
REQ-027 With the macro defined: a winner whose i_lock bit is high enters LOCK; in LOCK it keeps o_gnt every cycle its i_req stays high, o_data reloads its i_data each such cycle, o_upd=1, and ptr is frozen.
REQ-028 LOCK exit: owner's i_req or i_lock low, or lock counter reaching LOCK_MAX granted cycles, whichever comes first.
REQ-029 On LOCK exit, ptr <= owner+1 and arbitration resumes in the same cycle among the other requesters; the forced-release owner cannot win that cycle.
REQ-030 Without the macro: i_lock port, LOCK state and lock counter are absent; behaviour is REQ-014..REQ-023 only.

Verification
REQ-031 Reset, then i_req=4'b0000 for 5 cycles -> o_gnt=0, o_upd=0, o_data=RST_VALUE, o_owner=0 throughout.
REQ-032 i_req=4'b1111 held, data k = 0xA0+k -> o_gnt 0001,0010,0100,1000,0001; o_data 0xA0,0xA1,0xA2,0xA3,0xA0.
REQ-033 i_req=4'b1000 one cycle, then i_req=4'b1001 -> grant 3 (o_data=0xA3), then grant 0 via wrap (ptr=0).
REQ-034 LOCK_EN, LOCK_MAX=4, requester 1 i_req=i_lock=1 held, others requesting -> o_gnt=0010 exactly 4 cycles, then 0100.
REQ-035 i_rst pulsed high mid-lock between clock edges -> o_gnt=0, o_data=RST_VALUE before next edge; first grant after release goes to lowest requesting index.
